// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Booth vs radix-2 multiply is chosen in pipe_multdiv by MULTDIV_BOOTH_EN.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int N_MUL_RADIX2 = 32;
  localparam int N_MUL_BOOTH  = 16;
  localparam int DIV_ITERS    = 32;
  localparam int CNT_W        = 6;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  // 0x80000000 maps to 2^31, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/multdiv_booth_enc.sv
// Radix-4 modified Booth recoder: selects {0, +-1, +-2} * A from three multiplier bits.
// Instantiated only when MULTDIV_BOOTH_EN is defined.
module multdiv_booth_enc (
  input  logic [2:0]  bits_i,
  input  logic [31:0] a_i,
  output logic [33:0] pp_o
);

  logic [33:0] a_ext;

  assign a_ext = {{2{a_i[31]}}, a_i};

  always_comb begin
    pp_o = '0;
    case (bits_i)
      3'b001, 3'b010: pp_o = a_ext;
      3'b011:         pp_o = a_ext << 1;
      3'b100:         pp_o = -(a_ext << 1);
      3'b101, 3'b110: pp_o = -a_ext;
      default:        pp_o = '0;
    endcase
  end

endmodule

// File: rtl/pipe_multdiv.sv
// Iterative signed 32-bit multiply/divide with one shared 64-bit accumulator.
// Define MULTDIV_BOOTH_EN for radix-4 Booth multiply (16 iterations); default is radix-2 (32).
module pipe_multdiv
  import multdiv_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      data_operandA,
  input  logic [31:0]      data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [TAG_W-1:0] out_tag
);

`ifdef MULTDIV_BOOTH_EN
  localparam int N_MUL = N_MUL_BOOTH;
`else
  localparam int N_MUL = N_MUL_RADIX2;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d, out_tag_q, out_tag_d;
  logic [31:0]        result_q, result_d;
  logic               exc_q, exc_d;

  logic [63:0]        mul_next, div_next;
  logic [63:0]        div_shift;
  logic [32:0]        div_diff;
  logic [31:0]        b_mag;
  logic [32:0]        prod_top;
  logic               last_iter;

  assign last_iter = (cnt_q == CNT_W'(1));

`ifdef MULTDIV_BOOTH_EN
  logic        booth_q, booth_d;
  logic [33:0] booth_pp;
  logic [33:0] booth_sum;

  multdiv_booth_enc u_booth_enc (
    .bits_i ({acc_q[1:0], booth_q}),
    .a_i    (a_q),
    .pp_o   (booth_pp)
  );

  assign booth_sum = {{2{acc_q[63]}}, acc_q[63:32]} + booth_pp;
  assign mul_next  = {booth_sum, acc_q[31:2]};
`else
  logic [32:0] mul_hi, mul_a, mul_sum;

  // The multiplier MSB carries weight -2^31, so the final step subtracts.
  always_comb begin
    mul_hi = {acc_q[63], acc_q[63:32]};
    mul_a  = {a_q[31], a_q};
    if (!acc_q[0])
      mul_sum = mul_hi;
    else if (last_iter)
      mul_sum = mul_hi - mul_a;
    else
      mul_sum = mul_hi + mul_a;
  end

  assign mul_next = {mul_sum, acc_q[31:1]};
`endif

  assign prod_top  = mul_next[63:31];
  assign b_mag     = abs32(b_q);
  assign div_shift = {acc_q[62:0], 1'b0};
  assign div_diff  = {1'b0, div_shift[63:32]} - {1'b0, b_mag};
  assign div_next  = div_diff[32] ? div_shift : {div_diff[31:0], div_shift[31:1], 1'b1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    result_d  = result_q;
    exc_d     = exc_q;
`ifdef MULTDIV_BOOTH_EN
    booth_d   = booth_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          a_d     = data_operandA;
          b_d     = data_operandB;
          tag_d   = in_tag;
          acc_d   = {32'b0, data_operandB};
          cnt_d   = CNT_W'(N_MUL);
          state_d = ST_MUL;
`ifdef MULTDIV_BOOTH_EN
          booth_d = 1'b0;
`endif
        end else if (ctrl_DIV) begin
          a_d     = data_operandA;
          b_d     = data_operandB;
          tag_d   = in_tag;
          acc_d   = {32'b0, abs32(data_operandA)};
          cnt_d   = CNT_W'(DIV_ITERS);
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef MULTDIV_BOOTH_EN
        booth_d = acc_q[1];
`endif
        if (last_iter) begin
          state_d   = ST_DONE;
          out_tag_d = tag_q;
          result_d  = mul_next[31:0];
          exc_d     = !((&prod_top) || (~|prod_top));
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_iter) begin
          state_d   = ST_DONE;
          out_tag_d = tag_q;
          if (b_q == 32'd0) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
          end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            result_d = 32'h8000_0000;
            exc_d    = 1'b1;
          end else begin
            result_d = (a_q[31] ^ b_q[31]) ? 32'(-div_next[31:0]) : div_next[31:0];
            exc_d    = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      out_tag_q <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
      booth_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
`ifdef MULTDIV_BOOTH_EN
      booth_q   <= booth_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign out_tag        = out_tag_q;

endmodule
